// File: rtl/serial_alu_multiword.sv
// Bit-serial multiword ALU: NSHIFT bits per advance, LSB digit first, with arg2 sign/zero extension.
// Define SERIAL_ALU_SHIFT_EN to enable opcodes 8 (SHL1) and 9 (RCL1); otherwise they decode as MOV.
module serial_alu_multiword #(
   parameter int NSHIFT    = 2,
   parameter int REG_BITS  = 8,
   parameter int MAX_WORDS = 2,
   localparam int DPW = REG_BITS / NSHIFT,
   localparam int CW  = ($clog2(MAX_WORDS * DPW) > 1) ? $clog2(MAX_WORDS * DPW) : 1,
   localparam int WW  = ($clog2(MAX_WORDS) > 1) ? $clog2(MAX_WORDS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        op,
   input  logic [WW-1:0]     words_m1,
   input  logic [WW-1:0]     arg2_words_m1,
   input  logic              sext2,
   input  logic              advance,
   input  logic [NSHIFT-1:0] data_in1,
   input  logic [NSHIFT-1:0] data_in2,
   output logic [NSHIFT-1:0] data_out,
   output logic              out_valid,
   output logic              busy,
   output logic              op_done,
   output logic [CW-1:0]     counter,
   output logic              flag_c,
   output logic              flag_v,
   output logic              flag_s,
   output logic              flag_z
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [WW-1:0]     wm1_q, wm1_d, a2m1_q, a2m1_d;
   logic              sext2_q, sext2_d;
   logic [CW-1:0]     counter_q, counter_d;
   logic              carry_q, carry_d, sign2_q, sign2_d, zero_q, zero_d;
   logic              flag_c_q, flag_c_d, flag_v_q, flag_v_d;
   logic              flag_s_q, flag_s_d, flag_z_q, flag_z_d;

   logic              is_ext, is_last, arith, inv, cin0, cin, cout, c_msb, digit_zero;
   logic [NSHIFT-1:0] b_eff, bx, res;
   logic [NSHIFT:0]   sum;
`ifdef SERIAL_ALU_SHIFT_EN
   logic [NSHIFT:0]   shl;
`endif

   always_comb begin
      // Index arithmetic done in int so the digit bounds cannot wrap in CW bits.
      is_ext  = int'(counter_q) >= (int'(a2m1_q) + 1) * DPW;
      is_last = int'(counter_q) == (int'(wm1_q) + 1) * DPW - 1;
      arith   = (op_q < 4'd4);
      inv     = (op_q == 4'd1) || (op_q == 4'd3);
      case (op_q)
         4'd1:       cin0 = 1'b1;
         4'd2, 4'd3: cin0 = flag_c_q;
`ifdef SERIAL_ALU_SHIFT_EN
         4'd9:       cin0 = flag_c_q;
`endif
         default:    cin0 = 1'b0;
      endcase
      cin   = (counter_q == '0) ? cin0 : carry_q;
      b_eff = is_ext ? {NSHIFT{sext2_q & sign2_q}} : data_in2;
      bx    = inv ? ~b_eff : b_eff;
      sum   = {1'b0, data_in1} + {1'b0, bx} + {{NSHIFT{1'b0}}, cin};
      c_msb = data_in1[NSHIFT-1] ^ bx[NSHIFT-1] ^ sum[NSHIFT-1];
`ifdef SERIAL_ALU_SHIFT_EN
      shl   = {data_in1, cin};
`endif
      cout  = 1'b0;
      case (op_q)
         4'd0, 4'd1, 4'd2, 4'd3: begin
            res  = sum[NSHIFT-1:0];
            cout = sum[NSHIFT];
         end
         4'd4: res = data_in1 & b_eff;
         4'd5: res = data_in1 | b_eff;
         4'd6: res = data_in1 ^ b_eff;
`ifdef SERIAL_ALU_SHIFT_EN
         4'd8, 4'd9: begin
            res  = shl[NSHIFT-1:0];
            cout = shl[NSHIFT];
         end
`endif
         default: res = b_eff;
      endcase
      digit_zero = (res == '0);
   end

   assign busy      = (state_q == RUN);
   assign out_valid = busy & advance;
   assign op_done   = out_valid & is_last;
   assign data_out  = out_valid ? res : '0;
   assign counter   = counter_q;
   assign flag_c    = flag_c_q;
   assign flag_v    = flag_v_q;
   assign flag_s    = flag_s_q;
   assign flag_z    = flag_z_q;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      wm1_d     = wm1_q;
      a2m1_d    = a2m1_q;
      sext2_d   = sext2_q;
      counter_d = counter_q;
      carry_d   = carry_q;
      sign2_d   = sign2_q;
      zero_d    = zero_q;
      flag_c_d  = flag_c_q;
      flag_v_d  = flag_v_q;
      flag_s_d  = flag_s_q;
      flag_z_d  = flag_z_q;
      case (state_q)
         IDLE: if (start) begin
            op_d      = op;
            wm1_d     = words_m1;
            a2m1_d    = arg2_words_m1;
            sext2_d   = sext2;
            counter_d = '0;
            zero_d    = 1'b1;
            state_d   = RUN;
         end
         RUN: if (advance) begin
            counter_d = counter_q + CW'(1);
            carry_d   = cout;
            zero_d    = zero_q & digit_zero;
            if (!is_ext) sign2_d = data_in2[NSHIFT-1];
            if (is_last) begin
               flag_c_d = cout;
               flag_v_d = arith & (c_msb ^ cout);
               flag_s_d = res[NSHIFT-1];
               flag_z_d = zero_q & digit_zero &
                          (((op_q == 4'd2) || (op_q == 4'd3)) ? flag_z_q : 1'b1);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= '0;
         wm1_q     <= '0;
         a2m1_q    <= '0;
         sext2_q   <= 1'b0;
         counter_q <= '0;
         carry_q   <= 1'b0;
         sign2_q   <= 1'b0;
         zero_q    <= 1'b0;
         flag_c_q  <= 1'b0;
         flag_v_q  <= 1'b0;
         flag_s_q  <= 1'b0;
         flag_z_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         wm1_q     <= wm1_d;
         a2m1_q    <= a2m1_d;
         sext2_q   <= sext2_d;
         counter_q <= counter_d;
         carry_q   <= carry_d;
         sign2_q   <= sign2_d;
         zero_q    <= zero_d;
         flag_c_q  <= flag_c_d;
         flag_v_q  <= flag_v_d;
         flag_s_q  <= flag_s_d;
         flag_z_q  <= flag_z_d;
      end
   end

endmodule
